// File: rtl/store_byte_serializer.sv
// Store-side narrowing path: truncates a 32-bit register value to SB/SH/SW width
// and writes it little-endian to a byte-wide memory, one beat per mem_ack.
module store_byte_serializer #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    input  logic [1:0]            req_size,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  misaligned_err
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [31:0]           data_r, data_s;
    logic [1:0]            k_r, k_s;
    logic [1:0]            last_r, last_s;
    logic                  mem_we_r, mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
    logic [7:0]            mem_wdata_r, mem_wdata_s;
    logic                  done_r, done_s;
    logic                  err_r, err_s;
    logic                  ready_r, ready_s;
    logic                  busy_r, busy_s;

    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] k);
        case (k)
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            2'd3:    return d[31:24];
            default: return 8'h00;
        endcase
    endfunction

    // Legal stores never cross a word, so only the low two bits move.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [1:0] k);
        return {base[ADDR_WIDTH-1:2], base[1:0] + k};
    endfunction

    function automatic logic store_legal(input logic [1:0] lo, input logic [1:0] size);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return (lo[0] == 1'b0);
            2'b10:   return (lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] last_beat(input logic [1:0] size);
        case (size)
            2'b01:   return 2'd1;
            2'b10:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        data_s      = data_r;
        k_s         = k_r;
        last_s      = last_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_WIDTH{1'b0}};
        mem_wdata_s = 8'h00;
        done_s      = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && ready_r) begin
                    if (store_legal(req_addr[1:0], req_size)) begin
                        state_s     = SEND;
                        addr_s      = req_addr;
                        data_s      = req_data;
                        k_s         = 2'd0;
                        last_s      = last_beat(req_size);
                        mem_we_s    = 1'b1;
                        mem_addr_s  = req_addr;
                        mem_wdata_s = req_data[7:0];
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = mem_addr_r;
                mem_wdata_s = mem_wdata_r;
                if (mem_ack) begin
                    if (k_r == last_r) begin
                        state_s     = IDLE;
                        mem_we_s    = 1'b0;
                        mem_addr_s  = {ADDR_WIDTH{1'b0}};
                        mem_wdata_s = 8'h00;
                        done_s      = 1'b1;
                    end else begin
                        k_s         = k_r + 2'd1;
                        mem_addr_s  = beat_addr(addr_r, k_r + 2'd1);
                        mem_wdata_s = pick_byte(data_r, k_r + 2'd1);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
        busy_s  = (state_s == SEND);
    end

    // State and registered outputs; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            data_r      <= 32'h0000_0000;
            k_r         <= 2'd0;
            last_r      <= 2'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= 8'h00;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            data_r      <= data_s;
            k_r         <= k_s;
            last_r      <= last_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            done_r      <= done_s;
            err_r       <= err_s;
            ready_r     <= ready_s;
            busy_r      <= busy_s;
        end
    end

    assign req_ready      = ready_r;
    assign mem_we         = mem_we_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign misaligned_err = err_r;

endmodule

// File: tb/tb_store_byte_serializer.sv
// Self-checking bench for store_byte_serializer: directed table, hand-written
// corner sequences and randomized stores against a transaction-level model.
module tb_store_byte_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        misaligned_err;

    int n_checks = 0;
    int n_fail   = 0;

    store_byte_serializer #(.ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .busy(busy), .done(done), .misaligned_err(misaligned_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        int          waits;
        bit          exp_legal;
        int          exp_beats;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        if (sz == 2'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " ready"}, req_ready, 1);
        check({tag, " we"}, mem_we, 0);
        check({tag, " addr"}, mem_addr, 0);
        check({tag, " wdata"}, mem_wdata, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " err"}, misaligned_err, 0);
    endtask

    // Issue one store and follow it to completion, waiting `waits` cycles per beat.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input int waits, input bit exp_legal, input int exp_beats,
                             input int exp_done);
        int beat;
        int w;
        int cyc;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz; mem_ack = 1'b0;
        check("ready before accept", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        if (!exp_legal) begin
            check("reject err", misaligned_err, 1);
            check("reject we", mem_we, 0);
            check("reject done", done, 0);
            check("reject ready", req_ready, 1);
            @(negedge clk);
            check("reject err one cycle", misaligned_err, 0);
            check("reject we after", mem_we, 0);
            return;
        end
        beat = 0; w = 0; cyc = 1;
        while (beat < exp_beats && cyc < 100) begin
            check("beat we", mem_we, 1);
            check("beat addr", mem_addr, 64'(a + 32'(beat)));
            check("beat data", mem_wdata, 64'((d >> (8 * beat)) & 32'hFF));
            check("beat busy/ready/done", {busy, req_ready, done}, 3'b100);
            if (w < waits) begin
                mem_ack = 1'b0; w++;
            end else begin
                mem_ack = 1'b1; w = 0; beat++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        check("done pulse", done, 1);
        check("done cycle", cyc, exp_done);
        check("done we/ready/err", {mem_we, req_ready, misaligned_err}, 3'b010);
        @(negedge clk);
        check("done one cycle", done, 0);
    endtask

    vec_t tbl[$];

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0;
        req_size = 2'b00; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("after reset");

        tbl.push_back('{32'h100, 32'hDEADBEEF, 2'd2, 0, 1'b1, 4, 5});
        tbl.push_back('{32'h203, 32'h12345678, 2'd0, 0, 1'b1, 1, 2});
        tbl.push_back('{32'h011, 32'h0000ABCD, 2'd1, 0, 1'b0, 0, 0});
        tbl.push_back('{32'h022, 32'h11111111, 2'd2, 0, 1'b0, 0, 0});
        tbl.push_back('{32'h040, 32'h22222222, 2'd3, 0, 1'b0, 0, 0});
        tbl.push_back('{32'h040, 32'h0000A1B2, 2'd1, 3, 1'b1, 2, 9});
        tbl.push_back('{32'h042, 32'hCAFEF00D, 2'd1, 1, 1'b1, 2, 5});
        tbl.push_back('{32'h007, 32'h99887766, 2'd0, 2, 1'b1, 1, 4});
        tbl.push_back('{32'hFFFFFFFC, 32'h01020304, 2'd2, 0, 1'b1, 4, 5});
        foreach (tbl[i])
            run_store(tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].waits,
                      tbl[i].exp_legal, tbl[i].exp_beats, tbl[i].exp_done);

        // Back-to-back SB with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h300; req_data = 32'h000000AA; req_size = 2'd0;
        @(negedge clk);
        check("b2b first beat", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h300, 8'hAA});
        mem_ack = 1'b1;
        @(negedge clk);
        check("b2b first done", {done, req_ready}, 2'b11);
        req_addr = 32'h301; req_data = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b second beat", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h301, 8'h55});
        @(negedge clk);
        check("b2b second done", done, 1);
        mem_ack = 1'b0;
        @(negedge clk);

        // Reset during beat 2 of a word store.
        req_valid = 1'b1; req_addr = 32'h500; req_data = 32'h11223344; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0; mem_ack = 1'b1;
        check("rst beat0", {mem_addr, mem_wdata}, {32'h500, 8'h44});
        @(negedge clk);
        check("rst beat1", {mem_addr, mem_wdata}, {32'h501, 8'h33});
        reset = 1'b0;
        #1;
        check_reset_values("mid-transfer reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("held reset no done/we", {done, mem_we, misaligned_err}, 3'b000);
        end
        mem_ack = 1'b0;
        reset = 1'b1;
        run_store(32'h601, 32'h000000C3, 2'd0, 0, 1'b1, 1, 2);

        // Randomized stores against the transaction-level model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  sz;
            int          waits;
            bit          lg;
            int          nb;
            a     = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            d     = $urandom;
            sz    = 2'($urandom_range(0, 3));
            waits = $urandom_range(0, 2);
            lg    = model_legal(a, sz);
            nb    = lg ? (1 << sz) : 0;
            run_store(a, d, sz, waits, lg, nb, nb * (waits + 1) + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global invariant: completion and rejection never coincide.
    always @(negedge clk) begin
        if (done && misaligned_err) begin
            n_checks++;
            n_fail++;
            $display("FAIL done/err overlap: got 1 expected 0");
        end
    end

endmodule
